// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-setting controller.
// Holds the state encoding, the field limits and bit positions of the packed
// {hour,min,sec} time word, and small helpers for wrapped editing and blink masks.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOUR = 2'd1,
        ST_MIN  = 2'd2,
        ST_SEC  = 2'd3
    } state_e;

    localparam int unsigned TIME_W  = 24;
    localparam int unsigned FIELD_W = 8;

    localparam logic [FIELD_W-1:0] HOUR_MAX = 8'd23;
    localparam logic [FIELD_W-1:0] MIN_MAX  = 8'd59;
    localparam logic [FIELD_W-1:0] SEC_MAX  = 8'd59;

    localparam int unsigned HOUR_HI = 23;
    localparam int unsigned HOUR_LO = 16;
    localparam int unsigned MIN_HI  = 15;
    localparam int unsigned MIN_LO  = 8;
    localparam int unsigned SEC_HI  = 7;
    localparam int unsigned SEC_LO  = 0;

    // One step up or down inside 0..max, wrapping at both ends.
    function automatic logic [FIELD_W-1:0] wrap_step(input logic [FIELD_W-1:0] val,
                                                     input logic [FIELD_W-1:0] max,
                                                     input logic               up);
        if (up) begin
            return (val >= max) ? 8'd0 : val + 8'd1;
        end
        return (val == 8'd0) ? max : val - 8'd1;
    endfunction

    // Display blank mask {hour,min,sec} for the field edited in a given state.
    function automatic logic [2:0] field_mask(input state_e st);
        case (st)
            ST_HOUR: return 3'b100;
            ST_MIN:  return 3'b010;
            ST_SEC:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one active-low push key.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   key_n_i     raw asynchronous key, low = pressed
//   press_o     one-cycle pulse when a debounced press is accepted
// The accepted level changes only after DB_CNT consecutive samples that differ
// from it. Press-to-pulse latency is DB_CNT+3 cycles; releases make no pulse.
module key_debounce #(
    parameter int unsigned DB_CNT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DB_CNT + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_dly_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    // Synchroniser, stability filter and falling-edge detector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            if (sync2_q != level_q) begin
                if (cnt_q == CW'(DB_CNT - 1)) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
            level_dly_q <= level_q;
            press_q     <= level_dly_q & ~level_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the digital clock.
// Ports:
//   clk, rst_n                  clock and synchronous active-low reset
//   key_mode, key_inc, key_dec  raw active-low keys
//   time_in                     live time {hour,min,sec} from the counter
//   set_en                      counter hold while any field is being set
//   load, load_data             one-cycle load of the edited time into the counter
//   disp_data                   time to show: live in RUN, shadow while setting
//   blink                       blank mask {hour,min,sec}, 1 = field dark
//   mode                        0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DB_CNT    = 1_000_000,
    parameter int unsigned BLINK_CNT = 12_500_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_mode,
    input  logic              key_inc,
    input  logic              key_dec,
    input  logic [TIME_W-1:0] time_in,
    output logic              set_en,
    output logic              load,
    output logic [TIME_W-1:0] load_data,
    output logic [TIME_W-1:0] disp_data,
    output logic [2:0]        blink,
    output logic [1:0]        mode
);

    localparam int unsigned BW = $clog2(BLINK_CNT + 1);

    logic              mode_p;
    logic              inc_p;
    logic              dec_p;

    state_e            state_q;
    logic [TIME_W-1:0] shadow_q;
    logic              load_q;
    logic              set_en_q;
    logic [2:0]        blink_q;
    logic [BW-1:0]     blink_cnt_q;
    logic              phase_q;
    logic [TIME_W-1:0] disp_q;

    key_debounce #(.DB_CNT(DB_CNT)) u_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_mode),
        .press_o (mode_p)
    );

    key_debounce #(.DB_CNT(DB_CNT)) u_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_inc),
        .press_o (inc_p)
    );

    key_debounce #(.DB_CNT(DB_CNT)) u_dec (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_dec),
        .press_o (dec_p)
    );

    // Mode FSM with shadow editing, load strobe and blink timer.
    // Priority inside a SET state: mode pulse, then a lone inc/dec, then blink timing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            shadow_q    <= '0;
            load_q      <= 1'b0;
            set_en_q    <= 1'b0;
            blink_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            load_q <= 1'b0;
            if (state_q == ST_RUN) begin
                blink_q     <= '0;
                blink_cnt_q <= '0;
                phase_q     <= 1'b0;
                if (mode_p) begin
                    state_q  <= ST_HOUR;
                    shadow_q <= time_in;
                    set_en_q <= 1'b1;
                end
            end else if (mode_p) begin
                blink_q     <= '0;
                blink_cnt_q <= '0;
                phase_q     <= 1'b0;
                case (state_q)
                    ST_HOUR: state_q <= ST_MIN;
                    ST_MIN:  state_q <= ST_SEC;
                    default: begin
                        state_q  <= ST_RUN;
                        set_en_q <= 1'b0;
                        load_q   <= 1'b1;
                    end
                endcase
            end else if (inc_p ^ dec_p) begin
                // An accepted edit restarts the blink so the field is visible at once.
                blink_q     <= '0;
                blink_cnt_q <= '0;
                phase_q     <= 1'b0;
                case (state_q)
                    ST_HOUR: shadow_q[HOUR_HI:HOUR_LO] <=
                        wrap_step(shadow_q[HOUR_HI:HOUR_LO], HOUR_MAX, inc_p);
                    ST_MIN:  shadow_q[MIN_HI:MIN_LO] <=
                        wrap_step(shadow_q[MIN_HI:MIN_LO], MIN_MAX, inc_p);
                    default: shadow_q[SEC_HI:SEC_LO] <=
                        wrap_step(shadow_q[SEC_HI:SEC_LO], SEC_MAX, inc_p);
                endcase
            end else if (blink_cnt_q == BW'(BLINK_CNT - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
                blink_q     <= phase_q ? 3'b000 : field_mask(state_q);
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
        end
    end

    // Display source select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_q <= '0;
        end else begin
            disp_q <= (state_q == ST_RUN) ? time_in : shadow_q;
        end
    end

    assign set_en    = set_en_q;
    assign load      = load_q;
    assign load_data = shadow_q;
    assign disp_data = disp_q;
    assign blink     = blink_q;
    assign mode      = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce and blink periods.
module tb_clock_set_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned BL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_mode;
    logic        key_inc;
    logic        key_dec;
    logic [23:0] time_in;
    logic        set_en;
    logic        load;
    logic [23:0] load_data;
    logic [23:0] disp_data;
    logic [2:0]  blink;
    logic [1:0]  mode;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          inc_pulses = 0;
    int          inc_pulse_cyc = 0;
    int          load_cnt = 0;
    logic [23:0] load_seen = '0;
    logic        load_prev = 1'b0;
    logic        set_en_after = 1'b1;
    int          settle_cyc = 0;
    bit          found;

    clock_set_ctrl #(.DB_CNT(DB), .BLINK_CNT(BL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .key_dec   (key_dec),
        .time_in   (time_in),
        .set_en    (set_en),
        .load      (load),
        .load_data (load_data),
        .disp_data (disp_data),
        .blink     (blink),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and load monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (dut.inc_p === 1'b1) begin
            inc_pulses++;
            inc_pulse_cyc = cyc;
        end
        if (load_prev) set_en_after = set_en;
        if (load === 1'b1) begin
            load_cnt++;
            load_seen = load_data;
        end
        load_prev = (load === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the chosen keys long enough for one pulse, then release and let it settle.
    task automatic press(input bit m, input bit i, input bit d);
        if (m) key_mode = 1'b0;
        if (i) key_inc  = 1'b0;
        if (d) key_dec  = 1'b0;
        step(10);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        key_dec  = 1'b1;
        step(10);
    endtask

    // Hold inc until the shadow changes; returns with the key still held.
    task automatic inc_track(output bit seen);
        logic [23:0] prev;
        prev = load_data;
        seen = 1'b0;
        key_inc = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1);
            if (load_data !== prev) seen = 1'b1;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        key_mode = 1'b1;
        key_inc  = 1'b1;
        key_dec  = 1'b1;
        time_in  = 24'h0C1E2D;
        step(3);
        check("rst_mode",      32'(mode), 32'd0);
        check("rst_set_en",    32'(set_en), 32'd0);
        check("rst_load",      32'(load), 32'd0);
        check("rst_blink",     32'(blink), 32'd0);
        check("rst_load_data", 32'(load_data), 32'h0);
        rst_n = 1'b1;
        step(2);
        check("run_disp", 32'(disp_data), 32'h0C1E2D);

        // Bounce on inc in RUN: L H L H L, last low segment then held.
        for (int i = 0; i < 5; i++) begin
            key_inc = (i % 2 == 0) ? 1'b0 : 1'b1;
            if (i == 4) settle_cyc = cyc;
            step(2);
        end
        step(10);
        check("bounce_pulses",  32'(inc_pulses), 32'd1);
        check("bounce_latency", 32'(inc_pulse_cyc - settle_cyc), 32'd7);
        key_inc = 1'b1;
        step(12);
        check("release_no_pulse", 32'(inc_pulses), 32'd1);
        check("run_inc_ignored",  32'(load_data), 32'h0);
        check("run_mode",         32'(mode), 32'd0);

        // Full set sequence.
        time_in = 24'h173B3B;
        step(2);
        press(1, 0, 0);
        check("set_hour_mode",   32'(mode), 32'd1);
        check("set_hour_set_en", 32'(set_en), 32'd1);
        check("capture",         32'(load_data), 32'h173B3B);
        check("set_disp",        32'(disp_data), 32'h173B3B);
        press(0, 1, 0);
        check("hour_inc_wrap", 32'(load_data), 32'h003B3B);
        press(1, 0, 0);
        check("set_min_mode", 32'(mode), 32'd2);
        press(0, 0, 1);
        check("min_dec", 32'(load_data), 32'h003A3B);
        press(1, 0, 0);
        check("set_sec_mode", 32'(mode), 32'd3);
        press(0, 1, 0);
        check("sec_inc_wrap", 32'(load_data), 32'h003A00);
        check("no_load_yet", 32'(load_cnt), 32'd0);
        set_en_after = 1'b1;
        press(1, 0, 0);
        check("load_count",   32'(load_cnt), 32'd1);
        check("load_value",   32'(load_seen), 32'h003A00);
        check("set_en_after", 32'(set_en_after), 32'd0);
        check("back_run",     32'(mode), 32'd0);

        // Wrap cases.
        time_in = 24'h170000;
        step(2);
        press(1, 0, 0);
        check("capture2", 32'(load_data), 32'h170000);
        press(0, 1, 0);
        check("hour_23_inc", 32'(load_data), 32'h000000);
        press(0, 0, 1);
        check("hour_0_dec", 32'(load_data), 32'h170000);
        press(1, 0, 0);
        check("min_mode2", 32'(mode), 32'd2);
        press(0, 0, 1);
        check("min_0_dec", 32'(load_data), 32'h173B00);

        // Blink timing after an edit in SET_MIN.
        inc_track(found);
        check("edit_seen",  32'(found), 32'd1);
        check("min_59_inc", 32'(load_data), 32'h170000);
        check("blink_o0",   32'(blink), 32'b000);
        step(7);
        check("blink_o7",   32'(blink), 32'b000);
        step(1);
        check("blink_o8",   32'(blink), 32'b010);
        step(7);
        check("blink_o15",  32'(blink), 32'b010);
        step(1);
        check("blink_o16",  32'(blink), 32'b000);
        key_inc = 1'b1;
        step(8);
        check("blink_o24",  32'(blink), 32'b010);
        step(12);
        check("hold_one_edit", 32'(load_data), 32'h170000);
        inc_track(found);
        check("edit2_seen",     32'(found), 32'd1);
        check("min_inc",        32'(load_data), 32'h170100);
        check("restart_vis",    32'(blink), 32'b000);
        step(7);
        check("restart_o7",     32'(blink), 32'b000);
        step(1);
        check("restart_o8",     32'(blink), 32'b010);
        key_inc = 1'b1;
        step(12);

        // Collisions.
        press(0, 1, 1);
        check("incdec_nochange", 32'(load_data), 32'h170100);
        check("incdec_mode",     32'(mode), 32'd2);
        press(1, 1, 0);
        check("mode_inc_state",  32'(mode), 32'd3);
        check("mode_inc_noedit", 32'(load_data), 32'h170100);
        press(1, 0, 0);
        check("load2_count", 32'(load_cnt), 32'd2);
        check("load2_value", 32'(load_seen), 32'h170100);

        // Reset in the middle of setting.
        press(1, 0, 0);
        press(1, 0, 0);
        check("pre_rst_mode", 32'(mode), 32'd2);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        check("midrst_mode",   32'(mode), 32'd0);
        check("midrst_set_en", 32'(set_en), 32'd0);
        check("midrst_blink",  32'(blink), 32'd0);
        check("midrst_noload", 32'(load_cnt), 32'd2);
        check("midrst_shadow", 32'(load_data), 32'h0);
        check("midrst_disp",   32'(disp_data), 32'h170000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
